audio_fx_player: RTL and testbench
==================================

# audio_fx_player

Sound-effect generator and I2S transmitter for the WM8731 codec. It consumes the 2-bit `vga_audio_ctrl` effect code exported by the VGA/game peripheral inside `soc_system`, synthesizes a short enveloped effect, and drives `AUD_XCK`, `AUD_BCLK`, `AUD_DACLRCK` and `AUD_DACDAT` directly. Codec register setup over I2C (I2S slave mode, 16-bit, DAC enabled) is done by HPS software, not by this block.

## Interface
Parameters:
- `FX_LEN`, default 8192: samples per effect (power of two, ≥ 2048).
- `AMPLITUDE`, default 16'h2000: peak signed sample magnitude before envelope.

Ports:
- Clock and reset: one clock, `clk`; reset is synchronous and active-high, named `reset`.
- `clk`: input, 1 bit, 50 MHz system clock, the same clock that drives `soc_system`.
- `reset`: input, 1 bit, synchronous, active-high.
- `audio_ctrl`: input, 2 bits, effect code in the `clk` domain.
  - 00: none.
  - 01: laser.
  - 10: explosion.
  - 11: power-up.
- `aud_xck`: output, 1 bit, codec MCLK at 12.5 MHz.
- `aud_bclk`: output, 1 bit, bit clock at 3.125 MHz.
- `aud_daclrck`: output, 1 bit, 0 = left, 1 = right. Frame rate is 48.828 kHz.
- `aud_dacdat`: output, 1 bit, serial sample data.
- `busy`: output, 1 bit, high while an effect is playing.

## Operation
- Free-running 4-bit `clk_cnt` drives the clocks.
  - `aud_xck` = `clk_cnt[1]`.
  - `aud_bclk` = `clk_cnt[3]`.
  - A BCLK falling edge occurs on the `clk_cnt` 15→0 wrap.
- 6-bit `bit_cnt` advances on each BCLK falling edge. `aud_daclrck` = `bit_cnt[5]`.
- I2S format, per 32-bit channel half:
  - slot 0 is dummy (0);
  - slots 1..16 carry the sample, MSB first;
  - slots 17..31 are 0.
  - Data changes on the BCLK falling edge and is stable across the rising edge.
  - Left and right channels carry the same sample.
- Frame boundary (`bit_cnt` 63→0): the shift register loads `cur`, the combinational sample for the present state, and then the generator state advances.
- Trigger: `audio_ctrl != 0 && audio_ctrl != ctrl_q`, where `ctrl_q` is `audio_ctrl` delayed one cycle.
  - A trigger loads the effect, sets n=0, phase=0 and lfsr=16'hACE1, and enters PLAY.
  - A trigger is honoured in IDLE or PLAY; the latest trigger wins and restarts the effect.
  - Holding a code constant, or returning to 00, does not stop or restart an effect.
- FSM states are IDLE and PLAY. `busy` = (state == PLAY).
- In IDLE, `cur` = 0.
- At the boundary where n == FX_LEN−1, the final sample is loaded and the state goes to IDLE.
- Envelope: amp = AMPLITUDE >> n[12:11] (shift of 0..3). This uses the n bits for FX_LEN = 8192; scale accordingly for other lengths.
- Square effects use a 16-bit phase accumulator, `phase += step` per sample, with `cur` = phase[15] ? −amp : +amp.
  - Laser: step = 16'h0C00 − (n >> 2), falling from about 2.29 kHz to about 0.76 kHz.
  - Power-up: step = 16'h0200 + (n >> 2).
- Explosion uses a 16-bit Fibonacci LFSR with taps 16, 14, 13, 11, shifted once per sample. `cur` = lfsr[15] ? −amp : +amp, using the state before the shift.
- All arithmetic is 16-bit two's complement and wraps modulo 2^16. The phase accumulator is expected to wrap.

## Timing
- Reset values:
  - All outputs are 0.
  - `clk_cnt`, `bit_cnt`, n and phase are 0.
  - lfsr = 16'hACE1.
  - State is IDLE and the shift register is 0.
- Reset asserted mid-effect gives silence and `busy` = 0 on the next cycle.
- `busy` rises 1 cycle after the trigger cycle.
- The first effect sample loads at the next frame boundary and is on `aud_dacdat` from left slot 1, 1 BCLK (16 clk) after that boundary. Worst-case latency is about 1040 clk.
- BCLK period is 16 clk. LRCK period is 1024 clk, with a 50% duty cycle.
- A trigger on the same cycle as a frame boundary: the boundary loads the pre-trigger `cur`, and the new effect starts at the following frame.

## Configuration
- `AUDIO_FX_NOISE_EN` defined: code 10 plays LFSR noise as described above.
- Not defined: the LFSR is omitted. Code 10 plays a square wave with fixed step 16'h0100 (about 191 Hz) and the same envelope.

## Structure
- Package `audio_fx_pkg` holds:
  - the `fx_e` enum (NONE, LASER, EXPLOSION, POWERUP) and the `state_e` enum;
  - the step constants;
  - the LFSR seed and taps;
  - the frame slot constants.
- Sub-module `i2s_tx` owns `clk_cnt`, `bit_cnt`, the shift register and the clock outputs. It exports a one-cycle `frame_strobe` and takes a 16-bit sample input.

## Test plan
- Reset held for 3 cycles, then released:
  - all outputs read 0 during reset;
  - afterwards `aud_bclk` has period 16, `aud_daclrck` has period 1024, and `aud_xck` has period 4.
- Idle with no trigger for 4 frames: all serialized samples are 16'h0000 and `busy` stays 0.
- `audio_ctrl` 00→01 and held:
  - `busy` is 1 on the next cycle;
  - the first left and right samples decode to 16'h2000;
  - `busy` stays high for exactly 8192 frame boundaries, then returns to 0;
  - no retrigger occurs.
- `AUDIO_FX_NOISE_EN` defined, `audio_ctrl` 00→10: the first sample is 16'hE000 (seed bit15 = 1).
- Retrigger: 01 at frame 0, then 11 at frame 100. The sample counter restarts, `busy` stays high continuously, and 8192 frames follow the second trigger.
- Reset asserted at frame 50 of an effect: the next serialized word is 0 and `busy` = 0.

Source files
------------

// File: rtl/audio_fx_pkg.sv
// audio_fx_pkg: shared types and constants for the audio_fx_player sound-effect block.
// Holds the effect/state enums, oscillator step constants, LFSR seed/taps and
// I2S slot positions.
package audio_fx_pkg;

    typedef enum logic [1:0] {
        NONE      = 2'd0,
        LASER     = 2'd1,
        EXPLOSION = 2'd2,
        POWERUP   = 2'd3
    } fx_e;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    // Phase-accumulator step bases (added once per sample frame)
    localparam logic [15:0] LASER_STEP_BASE   = 16'h0C00;
    localparam logic [15:0] POWERUP_STEP_BASE = 16'h0200;
    localparam logic [15:0] BOOM_STEP         = 16'h0100;

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11: state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Sample occupies slots 1..16 of each 32-slot channel half, MSB first
    localparam logic [4:0] SLOT_MSB = 5'd1;
    localparam logic [4:0] SLOT_LSB = 5'd16;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/i2s_tx.sv
// i2s_tx: derives MCLK/BCLK/LRCK from a free-running counter and serializes a
// 16-bit sample into both I2S channel halves. frame_strobe marks the last cycle
// of each frame; the sample input is captured on that cycle.
module i2s_tx
    import audio_fx_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_sample,
    output logic        o_frame_strobe,
    output logic        o_xck,
    output logic        o_bclk,
    output logic        o_lrck,
    output logic        o_dat
);

    logic [3:0]  r_clk_cnt;
    logic [5:0]  r_bit_cnt;
    logic [15:0] r_shift;
    logic        r_dat;

    logic        w_bclk_fall;
    logic [4:0]  w_next_slot;
    logic [3:0]  w_bit_idx;
    logic        w_next_dat;

    assign w_bclk_fall    = (r_clk_cnt == 4'd15);
    assign o_frame_strobe = w_bclk_fall && (r_bit_cnt == 6'd63);
    assign w_next_slot    = r_bit_cnt[4:0] + 5'd1;
    assign w_bit_idx      = 4'(5'd16 - w_next_slot);

    // Select the data bit for the slot that begins at the coming BCLK fall
    always_comb begin
        w_next_dat = 1'b0;
        if ((w_next_slot >= SLOT_MSB) && (w_next_slot <= SLOT_LSB)) begin
            w_next_dat = r_shift[w_bit_idx];
        end else begin
            w_next_dat = 1'b0;
        end
    end

    // Clock counters, sample capture at frame end and data launch on BCLK fall
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_cnt <= 4'd0;
            r_bit_cnt <= 6'd0;
            r_shift   <= 16'd0;
            r_dat     <= 1'b0;
        end else begin
            r_clk_cnt <= r_clk_cnt + 4'd1;
            if (w_bclk_fall) begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
                r_dat     <= w_next_dat;
                if (o_frame_strobe) begin
                    r_shift <= i_sample;
                end
            end
        end
    end

    assign o_xck  = r_clk_cnt[1];
    assign o_bclk = r_clk_cnt[3];
    assign o_lrck = r_bit_cnt[5];
    assign o_dat  = r_dat;

endmodule

// File: rtl/audio_fx_player.sv
// audio_fx_player: enveloped sound-effect generator driving a WM8731 over I2S.
// Build option AUDIO_FX_NOISE_EN: when defined, the explosion code plays LFSR
// noise; when undefined the LFSR is not built and the explosion code plays a
// low fixed-step square wave with the same envelope.
module audio_fx_player
    import audio_fx_pkg::*;
#(
    parameter int          FX_LEN    = 8192,
    parameter logic [15:0] AMPLITUDE = 16'h2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] audio_ctrl,
    output logic       aud_xck,
    output logic       aud_bclk,
    output logic       aud_daclrck,
    output logic       aud_dacdat,
    output logic       busy
);

    // Envelope uses the two most significant bits of the sample index
    localparam int          ENV_MSB = $clog2(FX_LEN) - 1;
    localparam logic [15:0] LAST_N  = 16'(FX_LEN - 1);

    logic [1:0]  r_ctrl_q;
    state_e      r_state;
    fx_e         r_fx;
    logic [15:0] r_n;
    logic [15:0] r_phase;
    logic        r_busy;
`ifdef AUDIO_FX_NOISE_EN
    logic [15:0] r_lfsr;
`endif

    logic        w_trigger;
    logic        w_frame_strobe;
    logic [1:0]  w_env;
    logic [15:0] w_amp;
    logic [15:0] w_step;
    logic        w_neg;
    logic [15:0] w_cur;

    assign w_trigger = (audio_ctrl != 2'b00) && (audio_ctrl != r_ctrl_q);
    assign w_env     = r_n[ENV_MSB -: 2];

    // Current sample and next phase step for the playing effect
    always_comb begin
        w_amp  = AMPLITUDE >> w_env;
        w_neg  = r_phase[15];
        w_step = BOOM_STEP;
        case (r_fx)
            LASER:     w_step = LASER_STEP_BASE - (r_n >> 2);
            POWERUP:   w_step = POWERUP_STEP_BASE + (r_n >> 2);
            EXPLOSION: begin
                w_step = BOOM_STEP;
`ifdef AUDIO_FX_NOISE_EN
                w_neg  = r_lfsr[15];
`endif
            end
            default:   w_step = BOOM_STEP;
        endcase
        if (r_state == PLAY) begin
            w_cur = w_neg ? (16'd0 - w_amp) : w_amp;
        end else begin
            w_cur = 16'd0;
        end
    end

    // Effect FSM: a new code restarts the effect, frame ends advance it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_q <= 2'b00;
            r_state  <= IDLE;
            r_busy   <= 1'b0;
            r_fx     <= NONE;
            r_n      <= 16'd0;
            r_phase  <= 16'd0;
`ifdef AUDIO_FX_NOISE_EN
            r_lfsr   <= LFSR_SEED;
`endif
        end else begin
            r_ctrl_q <= audio_ctrl;
            if (w_trigger) begin
                r_fx    <= fx_e'(audio_ctrl);
                r_n     <= 16'd0;
                r_phase <= 16'd0;
`ifdef AUDIO_FX_NOISE_EN
                r_lfsr  <= LFSR_SEED;
`endif
                r_state <= PLAY;
                r_busy  <= 1'b1;
            end else if (w_frame_strobe && (r_state == PLAY)) begin
                r_phase <= r_phase + w_step;
`ifdef AUDIO_FX_NOISE_EN
                r_lfsr  <= lfsr_next(r_lfsr);
`endif
                if (r_n == LAST_N) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end else begin
                    r_n <= r_n + 16'd1;
                end
            end
        end
    end

    i2s_tx u_i2s (
        .clk            (clk),
        .reset          (reset),
        .i_sample       (w_cur),
        .o_frame_strobe (w_frame_strobe),
        .o_xck          (aud_xck),
        .o_bclk         (aud_bclk),
        .o_lrck         (aud_daclrck),
        .o_dat          (aud_dacdat)
    );

    assign busy = r_busy;

endmodule

// File: tb/tb_audio_fx_player.sv
// tb_audio_fx_player: self-checking bench for audio_fx_player with a short
// effect length. A cycle model of the generator pushes the expected word of
// each frame into a queue; a serial decoder pops and compares both channels.
`timescale 1ns/1ps
module tb_audio_fx_player;

    localparam int          FX_LEN = 16;
    localparam logic [15:0] AMP    = 16'h2000;
`ifdef AUDIO_FX_NOISE_EN
    localparam bit          NOISE      = 1'b1;
    localparam logic [15:0] BOOM_FIRST = 16'hE000;
`else
    localparam bit          NOISE      = 1'b0;
    localparam logic [15:0] BOOM_FIRST = 16'h2000;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] audio_ctrl = 2'b00;
    logic       aud_xck, aud_bclk, aud_daclrck, aud_dacdat, busy;

    audio_fx_player #(.FX_LEN(FX_LEN), .AMPLITUDE(AMP)) dut (
        .clk         (clk),
        .reset       (reset),
        .audio_ctrl  (audio_ctrl),
        .aud_xck     (aud_xck),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- reference model ----------------
    int          tb_t;
    logic        m_busy;
    logic [1:0]  m_fx, m_ctrlq;
    int          m_n;
    logic [15:0] m_phase, m_lfsr;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] model_cur(input logic b, input logic [1:0] fx, input int n,
                                              input logic [15:0] ph, input logic [15:0] lf);
        int   env;
        int   a;
        logic neg;
        if (!b) return 16'h0000;
        env = (n * 4) / FX_LEN;
        a   = int'(AMP) / (1 << env);
        neg = (NOISE && fx == 2'b10) ? lf[15] : ph[15];
        return neg ? 16'(65536 - a) : 16'(a);
    endfunction

    function automatic logic [15:0] model_step(input logic [1:0] fx, input int n);
        case (fx)
            2'b01:   return 16'(32'h0C00 - n / 4);
            2'b11:   return 16'(32'h0200 + n / 4);
            default: return 16'h0100;
        endcase
    endfunction

    function automatic logic [15:0] model_lfsr(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            tb_t    <= 0;
            m_busy  <= 1'b0;
            m_fx    <= 2'b00;
            m_ctrlq <= 2'b00;
            m_n     <= 0;
            m_phase <= 16'h0000;
            m_lfsr  <= 16'hACE1;
            exp_q.delete();
            exp_q.push_back(16'h0000);
        end else begin
            tb_t    <= tb_t + 1;
            m_ctrlq <= audio_ctrl;
            if (tb_t % 1024 == 1023)
                exp_q.push_back(model_cur(m_busy, m_fx, m_n, m_phase, m_lfsr));
            if (audio_ctrl != 2'b00 && audio_ctrl != m_ctrlq) begin
                m_busy  <= 1'b1;
                m_fx    <= audio_ctrl;
                m_n     <= 0;
                m_phase <= 16'h0000;
                m_lfsr  <= 16'hACE1;
            end else if (tb_t % 1024 == 1023 && m_busy) begin
                m_phase <= m_phase + model_step(m_fx, m_n);
                m_lfsr  <= model_lfsr(m_lfsr);
                if (m_n == FX_LEN - 1) m_busy <= 1'b0;
                else                   m_n    <= m_n + 1;
            end
        end
    end

    // ---------------- decoder / scoreboard ----------------
    bit          run_chk = 1'b0;
    int          words_done = 0;
    logic [15:0] last_word = 16'h0000;

    initial begin : decoder
        logic [15:0] dec_word;
        logic        pad_bad;
        logic [15:0] w;
        int          slot;
        bit          right;
        dec_word = 16'h0000;
        pad_bad  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                dec_word = 16'h0000;
                pad_bad  = 1'b0;
            end else if (run_chk) begin
                check("xck", aud_xck, tb_t[1]);
                check("bclk", aud_bclk, tb_t[3]);
                check("lrck", aud_daclrck, tb_t[9]);
                check("busy", busy, m_busy);
                if (tb_t % 16 == 8) begin
                    slot  = (tb_t / 16) % 32;
                    right = ((tb_t / 16) % 64) >= 32;
                    if (slot >= 1 && slot <= 16) begin
                        dec_word = {dec_word[14:0], aud_dacdat};
                    end else if (aud_dacdat !== 1'b0) begin
                        pad_bad = 1'b1;
                    end
                    if (slot == 16) begin
                        w = dec_word;
                        if (exp_q.size() == 0) begin
                            fail_now("scoreboard_empty");
                        end else begin
                            check(right ? "word_right" : "word_left", w, exp_q[0]);
                            if (right) begin
                                void'(exp_q.pop_front());
                                words_done++;
                            end
                        end
                        last_word = w;
                    end
                    if (slot == 31) begin
                        check("pad_zero", pad_bad, 1'b0);
                        pad_bad = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_frame_start();
        int guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tb_t % 1024 != 32 && guard < 2100);
        if (guard >= 2100) fail_now("frame_align");
    endtask

    task automatic wait_words(input int target);
        int guard = 0;
        while (words_done < target && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        if (words_done < target) fail_now("word_wait");
    endtask

    task automatic wait_busy_low();
        int guard = 0;
        while (busy !== 1'b0 && guard < 20 * 1024) begin
            @(negedge clk);
            guard++;
        end
        if (busy !== 1'b0) fail_now("busy_low_wait");
    endtask

    typedef struct {
        logic [1:0]  code;
        logic [15:0] first;
        bit          full;
    } vec_t;

    vec_t vecs[3];
    int   w0;
    int   b0;
    bit   drop;
    int   guard;

    initial begin : main
        vecs[0] = '{2'b01, 16'h2000, 1'b1};
        vecs[1] = '{2'b10, BOOM_FIRST, 1'b0};
        vecs[2] = '{2'b11, 16'h2000, 1'b0};

        // Reset for 3 cycles: every output low
        reset      = 1'b1;
        audio_ctrl = 2'b00;
        repeat (3) begin
            @(negedge clk);
            check("rst_xck", aud_xck, 1'b0);
            check("rst_bclk", aud_bclk, 1'b0);
            check("rst_lrck", aud_daclrck, 1'b0);
            check("rst_dat", aud_dacdat, 1'b0);
            check("rst_busy", busy, 1'b0);
        end
        reset   = 1'b0;
        run_chk = 1'b1;

        // Idle for 4 frames: zero words, not busy
        repeat (4 * 1024) @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_word", last_word, 16'h0000);

        // Table of effect triggers
        for (int i = 0; i < 3; i++) begin
            wait_frame_start();
            w0         = words_done;
            b0         = tb_t / 1024;
            audio_ctrl = vecs[i].code;
            @(negedge clk);
            check("busy_rise", busy, 1'b1);
            wait_words(w0 + 2);
            check("first_word", last_word, vecs[i].first);
            if (vecs[i].full) begin
                wait_busy_low();
                check("effect_frames", tb_t / 1024 - b0, FX_LEN);
                repeat (2048) @(negedge clk);
                check("no_retrigger", busy, 1'b0);
            end else begin
                audio_ctrl = 2'b00;
                repeat (2048) @(negedge clk);
                check("busy_hold", busy, 1'b1);
            end
        end

        // Retrigger: laser, then power-up four frames later
        wait_frame_start();
        audio_ctrl = 2'b01;
        @(negedge clk);
        check("retrig_busy1", busy, 1'b1);
        drop = 1'b0;
        repeat (4 * 1024) begin
            @(negedge clk);
            if (busy !== 1'b1) drop = 1'b1;
        end
        audio_ctrl = 2'b11;
        b0 = tb_t / 1024;
        @(negedge clk);
        check("retrig_busy2", busy, 1'b1);
        wait_busy_low();
        check("retrig_frames", tb_t / 1024 - b0, FX_LEN);
        check("retrig_cont", drop, 1'b0);

        // Trigger on the frame-boundary cycle, then reset mid-effect
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tb_t % 1024 != 1023 && guard < 2100);
        if (guard >= 2100) fail_now("boundary_align");
        audio_ctrl = 2'b01;
        @(negedge clk);
        check("edge_trig_busy", busy, 1'b1);
        repeat (5 * 1024 + 300) @(negedge clk);
        check("pre_reset_busy", busy, 1'b1);
        reset      = 1'b1;
        audio_ctrl = 2'b00;
        @(negedge clk);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_dat", aud_dacdat, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        w0    = words_done;
        wait_words(w0 + 1);
        check("post_rst_word", last_word, 16'h0000);
        repeat (1024) @(negedge clk);
        check("post_rst_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
